// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered multiplexer.
// The optional bus-lock feature is enabled with the RR_MUX_LOCK_EN macro.
package rr_mux_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Explicit compare against n-1 so non-power-of-two N wraps correctly.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req starting just after last,
// wrapping modulo N, and reports a one-hot grant, its binary index and any.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [SW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = SW'(wrap_inc(int'(last), N));
        for (int k = 0; k < N; k++) begin
            if (!any && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
            pos = SW'(wrap_inc(int'(pos), N));
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-input registered multiplexer with round-robin arbitration and valid/ready
// on every channel. Define RR_MUX_LOCK_EN to add the in_lock bus-lock input.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]   in_lock,
`endif
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    out_state_e    state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] last_q, last_d;

    logic [W-1:0]  data_ch [N];
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [SW-1:0] grant_idx;
    logic          grant_any;
    logic          can_load;
    logic          xfer;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        assign data_ch[gi] = in_data[gi*W +: W];
    end

`ifdef RR_MUX_LOCK_EN
    logic          locked_q, locked_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic [N-1:0]  lock_mask;

    // While locked only the owning channel may be picked, even if it idles.
    assign lock_mask = {{(N-1){1'b0}}, 1'b1} << lock_ch_q;
    assign req       = locked_q ? (in_valid & lock_mask) : in_valid;
`else
    assign req = in_valid;
`endif

    rr_arbiter #(.N(N), .SW(SW)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign can_load = (state_q == ST_EMPTY) || out_ready;
    assign in_ready = (rst_n && can_load) ? grant : '0;
    assign xfer     = rst_n && can_load && grant_any;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= SW'(N - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (!xfer && out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        last_d = last_q;
        if (xfer) begin
            data_d = data_ch[grant_idx];
            sel_d  = grant_idx;
            last_d = grant_idx;
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            locked_q  <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            locked_q  <= locked_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    always_comb begin
        locked_d  = locked_q;
        lock_ch_d = lock_ch_q;
        if (xfer) begin
            locked_d  = in_lock[grant_idx];
            lock_ch_d = grant_idx;
        end
    end
`endif

    always_comb begin
        out_valid = (state_q == ST_FULL);
        out_data  = data_q;
        out_sel   = sel_q;
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: an N=4/W=32 instance and an N=3/W=8 instance
// share clock and reset; expected values are hand-computed per step.
module tb_rr_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Instance A: N=4, W=32
    logic [3:0]   a_valid;
    logic [127:0] a_data;
    logic [3:0]   a_ready;
    logic         a_ovalid;
    logic [31:0]  a_odata;
    logic [1:0]   a_osel;
    logic         a_oready;
`ifdef RR_MUX_LOCK_EN
    logic [3:0]   a_lock;
`endif

    // Instance B: N=3, W=8
    logic [2:0]   b_valid;
    logic [23:0]  b_data;
    logic [2:0]   b_ready;
    logic         b_ovalid;
    logic [7:0]   b_odata;
    logic [1:0]   b_osel;
    logic         b_oready;
`ifdef RR_MUX_LOCK_EN
    logic [2:0]   b_lock;
`endif

    rr_mux_reg #(.N(4), .W(32)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid),
        .in_data   (a_data),
`ifdef RR_MUX_LOCK_EN
        .in_lock   (a_lock),
`endif
        .in_ready  (a_ready),
        .out_valid (a_ovalid),
        .out_data  (a_odata),
        .out_sel   (a_osel),
        .out_ready (a_oready)
    );

    rr_mux_reg #(.N(3), .W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_valid),
        .in_data   (b_data),
`ifdef RR_MUX_LOCK_EN
        .in_lock   (b_lock),
`endif
        .in_ready  (b_ready),
        .out_valid (b_ovalid),
        .out_data  (b_odata),
        .out_sel   (b_osel),
        .out_ready (b_oready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t A v=%b sel=%0d data=%h rdy=%b | B v=%b sel=%0d data=%h rdy=%b",
                 $time, a_ovalid, a_osel, a_odata, a_ready, b_ovalid, b_osel, b_odata, b_ready);
    endtask

    initial begin
        rst_n    = 1'b0;
        a_valid  = 4'b1111;
        a_oready = 1'b1;
        a_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        b_valid  = 3'b111;
        b_oready = 1'b1;
        b_data   = {8'hB2, 8'hB1, 8'hB0};
`ifdef RR_MUX_LOCK_EN
        a_lock   = 4'b0000;
        b_lock   = 3'b000;
`endif

        // Reset held for two cycles with every channel requesting
        step();
        step();
        chk("rst_a_valid", 32'(a_ovalid), 32'd0);
        chk("rst_a_data",  a_odata,       32'd0);
        chk("rst_a_ready", 32'(a_ready),  32'd0);
        chk("rst_b_valid", 32'(b_ovalid), 32'd0);
        chk("rst_b_ready", 32'(b_ready),  32'd0);
        rst_n   = 1'b1;
        b_valid = 3'b101;
        #1;
        chk("rel_a_ready", 32'(a_ready), 32'h1);
        chk("rel_b_ready", 32'(b_ready), 32'h1);

        // A: rotation 0,1,2,3,0 with no bubbles. B: wrap on N=3 with 3'b101.
        step();
        chk("rot0_valid", 32'(a_ovalid), 32'd1);
        chk("rot0_sel",   32'(a_osel),   32'd0);
        chk("rot0_data",  a_odata,       32'hA0);
        chk("wrap0_sel",  32'(b_osel),   32'd0);
        chk("wrap0_data", 32'(b_odata),  32'hB0);
        step();
        chk("rot1_sel",   32'(a_osel),   32'd1);
        chk("rot1_data",  a_odata,       32'hA1);
        chk("wrap1_sel",  32'(b_osel),   32'd2);
        chk("wrap1_data", 32'(b_odata),  32'hB2);
        step();
        chk("rot2_sel",   32'(a_osel),   32'd2);
        chk("rot2_data",  a_odata,       32'hA2);
        chk("wrap2_sel",  32'(b_osel),   32'd0);
        b_valid = 3'b100;
        step();
        chk("rot3_valid", 32'(a_ovalid), 32'd1);
        chk("rot3_sel",   32'(a_osel),   32'd3);
        chk("rot3_data",  a_odata,       32'hA3);
        chk("wrap3_sel",  32'(b_osel),   32'd2);
        b_valid = 3'b011;
        #1;
        chk("wrap_ready", 32'(b_ready), 32'h1);
        step();
        chk("rot4_sel",   32'(a_osel),   32'd0);
        chk("rot4_data",  a_odata,       32'hA0);
        chk("wrap4_sel",  32'(b_osel),   32'd0);
        b_valid = 3'b000;

        // Backpressure on channel 2
        a_valid        = 4'b0100;
        a_data[64 +: 32] = 32'hC2;
        step();
        chk("bp_load_sel",  32'(a_osel), 32'd2);
        chk("bp_load_data", a_odata,     32'hC2);
        a_oready         = 1'b0;
        a_data[64 +: 32] = 32'hC3;
        #1;
        chk("bp_ready0", 32'(a_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 32'(a_ovalid), 32'd1);
            chk("bp_hold_data",  a_odata,       32'hC2);
            chk("bp_hold_ready", 32'(a_ready),  32'h0);
        end
        a_oready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a_ready), 32'h4);
        step();
        chk("bp_reload_valid", 32'(a_ovalid), 32'd1);
        chk("bp_reload_data",  a_odata,       32'hC3);

        // Idle cycles do not rotate priority
        a_valid          = 4'b0010;
        a_data[32 +: 32] = 32'hB1;
        step();
        chk("idle_grant_sel", 32'(a_osel), 32'd1);
        a_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_valid", 32'(a_ovalid), 32'd0);
        end
        a_valid = 4'b0111;
        #1;
        chk("idle_ready", 32'(a_ready), 32'h4);
        step();
        chk("idle_after_sel",  32'(a_osel), 32'd2);
        chk("idle_after_data", a_odata,     32'hC3);

        // Reset while full discards the held word
        a_oready = 1'b0;
        rst_n    = 1'b0;
        step();
        chk("midrst_valid", 32'(a_ovalid), 32'd0);
        chk("midrst_data",  a_odata,       32'd0);
        chk("midrst_ready", 32'(a_ready),  32'h0);
        rst_n    = 1'b1;
        a_oready = 1'b1;
        a_valid  = 4'b0000;

`ifdef RR_MUX_LOCK_EN
        // Locked burst on channel 1 while channel 3 competes
        a_valid = 4'b1010;
        a_lock  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lock_sel", 32'(a_osel), 32'd1);
        end
        a_lock = 4'b0000;
        step();
        chk("unlock_beat_sel", 32'(a_osel), 32'd1);
        step();
        chk("after_lock_sel", 32'(a_osel), 32'd3);
        a_valid = 4'b0000;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
